// File: rtl/sig_div.sv
// Sequential restoring divider for half-precision significands: q = ({azero,a}<<13) / {bzero,b}, one quotient bit per cycle.
// Optional build macro SIGDIV_EARLY_EXIT_EN: finish as soon as the remaining work can only produce zero quotient bits.
module sig_div (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    input  logic        azero,
    input  logic        bzero,
    output logic [23:0] q,
    output logic [10:0] rem,
    output logic        sticky,
    output logic        dz,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_reg;
    logic [23:0] d_reg;
    logic [23:0] qw_reg;
    logic [10:0] bb_reg;
    logic [10:0] r_reg;
    logic [4:0]  cnt_reg;

    logic [11:0] r_shift;
    logic [11:0] r_next;
    logic        q_bit;
    logic [23:0] d_next;
    logic [23:0] qw_next;
    logic [23:0] q_final;
    logic [4:0]  cnt_next;
    logic        finish;

    // The partial remainder always stays below the divisor, so 11 stored bits suffice.
    always_comb begin
        r_shift  = {r_reg, d_reg[23]};
        q_bit    = (r_shift >= {1'b0, bb_reg});
        r_next   = q_bit ? (r_shift - {1'b0, bb_reg}) : r_shift;
        d_next   = {d_reg[22:0], 1'b0};
        qw_next  = {qw_reg[22:0], q_bit};
        cnt_next = cnt_reg - 5'd1;
`ifdef SIGDIV_EARLY_EXIT_EN
        finish   = (cnt_next == 5'd0) || ((r_next == 12'd0) && (d_next == 24'd0));
        q_final  = qw_next << cnt_next;
`else
        finish   = (cnt_next == 5'd0);
        q_final  = qw_next;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            qw_reg    <= '0;
            bb_reg    <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            q         <= '0;
            rem       <= '0;
            sticky    <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if ({bzero, b} == 11'd0) begin
                            q      <= 24'hFFFFFF;
                            rem    <= '0;
                            sticky <= 1'b0;
                            dz     <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            d_reg     <= {azero, a, 13'b0};
                            bb_reg    <= {bzero, b};
                            r_reg     <= '0;
                            qw_reg    <= '0;
                            cnt_reg   <= 5'd24;
                            busy      <= 1'b1;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    d_reg   <= d_next;
                    r_reg   <= r_next[10:0];
                    qw_reg  <= qw_next;
                    cnt_reg <= cnt_next;
                    if (finish) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        q         <= q_final;
                        rem       <= r_next[10:0];
                        sticky    <= |r_next;
                        dz        <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
